// File: rtl/uart_tx.sv
// UART transmitter: frames a parallel word (start, data LSB-first, optional parity, stop)
// and shifts it out on tx, one bit per external baud_tick period.
module uart_tx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  typedef enum logic [2:0] {StIdle, StSync, StStart, StData, StParity, StStop} state_e;

  localparam logic [3:0] LastBit   = 4'(DATA_BITS - 1);
  localparam logic [1:0] LastStop  = 2'(STOP_BITS - 1);
  localparam logic       ParityOdd = (PARITY_ODD != 0);

  state_e               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [3:0]           bit_cnt;
  logic [1:0]           stop_cnt;
  logic                 parity_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= StIdle;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      parity_bit <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          tx <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift_reg  <= tx_data;
            parity_bit <= (^tx_data) ^ ParityOdd;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= StSync;
          end
        end
        // A tick on the accept edge was seen in StIdle, so only later ticks land here,
        // which keeps the start bit a full period long.
        StSync: begin
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= StStart;
          end
        end
        StStart: begin
          if (baud_tick) begin
            tx      <= shift_reg[0];
            bit_cnt <= '0;
            state   <= StData;
          end
        end
        StData: begin
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == LastBit) begin
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= StParity;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= '0;
                state    <= StStop;
              end
            end else begin
              tx <= shift_reg[1];
            end
          end
        end
        StParity: begin
          if (baud_tick) begin
            tx       <= 1'b1;
            stop_cnt <= '0;
            state    <= StStop;
          end
        end
        StStop: begin
          if (baud_tick) begin
            if (stop_cnt == LastStop) begin
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              state    <= StIdle;
            end else begin
              stop_cnt <= stop_cnt + 2'd1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= StIdle;
        end
      endcase
    end
  end

endmodule
